// File: rtl/neuron_pkg.sv
// Shared Q-format constants, sequencer state type and the saturating shift
// also used by the activation stage.
package neuron_pkg;

    localparam int unsigned Q_DATA_W    = 16;
    localparam int unsigned Q_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DONE
    } state_e;

    // Arithmetic shift (floor) then clamp into a signed WIDTH-bit range.
    // Works on a 64-bit signed container; callers take the low WIDTH bits.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int unsigned        frac,
        input int unsigned        width
    );
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (sh > hi)      sat_shift = hi;
        else if (sh < lo) sat_shift = lo;
        else              sat_shift = sh;
    endfunction

endpackage

// File: rtl/neuron_rom_sequencer_if.sv
// ROM port plus input-sample and result valid/ready streams of one neuron.
interface neuron_rom_sequencer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              x_valid;
    logic [DATA_W-1:0] x_data;
    logic              x_ready;
    logic              y_valid;
    logic [DATA_W-1:0] y_data;
    logic              y_ready;

    modport master (
        output rom_addr, x_ready, y_valid, y_data,
        input  rom_dout, x_valid, x_data, y_ready
    );

    modport slave (
        input  rom_addr, x_ready, y_valid, y_data,
        output rom_dout, x_valid, x_data, y_ready
    );
endinterface

// File: rtl/neuron_mac.sv
// Signed DATA_W x DATA_W multiply feeding a sign-extended ACC_W accumulator.
module neuron_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign prod = a * b;

    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/neuron_rom_sequencer.sv
// Walks a neuron's weight ROM, pairs each weight with one input sample and
// presents the saturated Q-format pre-activation on a valid/ready output.
module neuron_rom_sequencer
    import neuron_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = Q_DATA_W,
    parameter int unsigned FRAC_BITS = Q_FRAC_BITS,
    parameter int unsigned N_INPUTS  = 10,
    parameter int unsigned BASE_ADDR = 1,
    parameter int unsigned ACC_W     = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    neuron_rom_sequencer_if.master bus
);
    localparam int unsigned IDX_W = 9;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [63:0]       sat_full;
    logic                     unused_sat_hi;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mac_clr    = 1'b1;
                    idx_d      = '0;
                    rom_addr_d = ADDR_W'(BASE_ADDR);
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: state_d = S_MAC;
            S_MAC: begin
                // Address only advances on an accept, so stalls keep the weight valid.
                if (bus.x_valid) begin
                    mac_en = 1'b1;
                    if (idx_q == IDX_W'(N_INPUTS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (bus.y_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (bus.x_data),
        .b   (bus.rom_dout),
        .acc (acc)
    );

    // acc only moves in MAC, so the result is stable throughout DONE.
    assign sat_full      = sat_shift({{(64-ACC_W){acc[ACC_W-1]}}, acc}, FRAC_BITS, DATA_W);
    assign unused_sat_hi = ^sat_full[63:DATA_W];

    assign bus.rom_addr = rom_addr_q;
    assign bus.x_ready  = (state_q == S_MAC);
    assign bus.y_valid  = (state_q == S_DONE);
    assign bus.y_data   = sat_full[DATA_W-1:0];
    assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_neuron_rom_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// them on every output handshake; the model is plain integer arithmetic.
module tb_neuron_rom_sequencer;
    localparam int N    = 10;
    localparam int BASE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;

    neuron_rom_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    neuron_rom_sequencer #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .FRAC_BITS (8),
        .N_INPUTS  (N),
        .BASE_ADDR (BASE),
        .ACC_W     (40)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [16];
    logic [15:0] cur_x   [N];
    logic [15:0] exp_q   [$];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    bit lat_check = 1'b0;
    bit yv_prev = 1'b0;
    bit stall_prev = 1'b0;
    logic [15:0] addr_prev = '0;

    always @(posedge clk) bus.rom_dout <= (bus.rom_addr < 16) ? rom_mem[bus.rom_addr[3:0]] : 16'h0;
    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model();
        longint acc = 0;
        for (int i = 0; i < N; i++)
            acc += longint'($signed(cur_x[i])) * longint'($signed(rom_mem[BASE + i]));
        acc = acc >>> 8;
        if (acc > 32767)       acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    // Output monitor: scoreboard pop, first-valid latency, stall address hold.
    always @(negedge clk) begin
        if (!rst && bus.y_valid && !yv_prev && lat_check)
            chk("latency", edge_cnt - start_edge, 2 * N);
        if (!rst && bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_y: got %0h required no output", bus.y_data);
            end else begin
                chk("y_data", bus.y_data, exp_q.pop_front());
            end
        end
        yv_prev = bus.y_valid;
        if (!rst && stall_prev) chk("stall_addr", bus.rom_addr, addr_prev);
        stall_prev = !rst && bus.x_ready && !bus.x_valid;
        addr_prev  = bus.rom_addr;
    end

    task automatic set_rom_default();
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'h0;
        for (int i = 1; i <= 6; i++) rom_mem[i] = 16'(i << 8);
    endtask

    task automatic fill_x(input logic [15:0] v);
        for (int i = 0; i < N; i++) cur_x[i] = v;
    endtask

    task automatic do_run(input int stall_pct, input int yhold, input logic [15:0] expv, input bit lat);
        int k = 0;
        int guard = 0;
        exp_q.push_back(expv);
        lat_check   = lat;
        bus.y_ready = (yhold == 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_edge = edge_cnt;
        while (k < N && guard < 400) begin
            bus.x_valid = ($urandom_range(99) >= stall_pct);
            bus.x_data  = bus.x_valid ? cur_x[k] : 16'($urandom);
            @(negedge clk);
            if (bus.x_valid && bus.x_ready) begin
                chk("accept_addr", bus.rom_addr, BASE + k);
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.x_valid = 1'b0;
        chk("accept_count", k, N);
        guard = 0;
        while (!bus.y_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("y_valid_seen", bus.y_valid, 1);
        for (int i = 0; i < yhold; i++) begin
            start = (i % 2 == 1);
            @(negedge clk);
            chk("hold_valid", bus.y_valid, 1);
            chk("hold_data", bus.y_data, expv);
            chk("hold_busy", busy, 1);
            @(posedge clk); #1;
        end
        bus.y_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_hs", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("start_ignored", busy, 0);
        lat_check = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        set_rom_default();
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_x_ready", bus.x_ready, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_y_data", bus.y_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        fill_x(16'h0100); do_run(0, 0, 16'h1500, 1'b1);
        fill_x(16'h7FFF); do_run(0, 0, 16'h7FFF, 1'b1);
        fill_x(16'h8000); do_run(0, 0, 16'h8000, 1'b1);
        fill_x(16'hFF00); do_run(0, 0, 16'hEB00, 1'b1);
        fill_x(16'h0100); do_run(40, 0, 16'h1500, 1'b0);
        fill_x(16'h0100); do_run(0, 5, 16'h1500, 1'b0);

        // Abort a run in MAC at idx 4; nothing may reach the output.
        for (int i = 0; i < N; i++) cur_x[i] = 16'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        bus.x_valid = 1'b1;
        for (int g = 0; g < 40 && k < 4; g++) begin
            bus.x_data = cur_x[k];
            @(negedge clk);
            if (bus.x_ready) k++;
            @(posedge clk); #1;
        end
        bus.x_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_in_mac", bus.x_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_addr", bus.rom_addr, 0);
        chk("abort_x_ready", bus.x_ready, 0);
        chk("abort_y_valid", bus.y_valid, 0);
        chk("abort_y_data", bus.y_data, 0);
        @(posedge clk); #1;
        fill_x(16'h0100); do_run(0, 0, 16'h1500, 1'b1);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) rom_mem[BASE + i] = 16'($urandom);
                else            rom_mem[BASE + i] = 16'(int'($urandom_range(2048)) - 1024);
                cur_x[i] = (r % 3 == 0) ? 16'($urandom) : 16'(int'($urandom_range(4096)) - 2048);
            end
            do_run(int'($urandom_range(50)), int'($urandom_range(3)), model(), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
